// File: rtl/sad_min_tracker_if.sv
// rtl/sad_min_tracker_if.sv - candidate stream in, best-match report out
interface sad_min_tracker_if #(
   parameter int SAD_W   = 32,
   parameter int COORD_W = 10,
   parameter int CNT_W   = 12
);
   logic               iFRAME_START;
   logic               iFRAME_END;
   logic               iVALID;
   logic [SAD_W-1:0]   iSAD;
   logic [COORD_W-1:0] iX;
   logic [COORD_W-1:0] iY;
   logic [COORD_W-1:0] oBEST_X;
   logic [COORD_W-1:0] oBEST_Y;
   logic [SAD_W-1:0]   oBEST_SAD;
   logic [CNT_W-1:0]   oCAND_CNT;
   logic               oFOUND;
   logic               oLOST;
   logic               oRESULT_VALID;
   logic               oBUSY;

   modport slave (
      input  iFRAME_START, iFRAME_END, iVALID, iSAD, iX, iY,
      output oBEST_X, oBEST_Y, oBEST_SAD, oCAND_CNT, oFOUND, oLOST,
             oRESULT_VALID, oBUSY
   );

   modport master (
      output iFRAME_START, iFRAME_END, iVALID, iSAD, iX, iY,
      input  oBEST_X, oBEST_Y, oBEST_SAD, oCAND_CNT, oFOUND, oLOST,
             oRESULT_VALID, oBUSY
   );
endinterface

// File: rtl/sad_min_tracker.sv
// rtl/sad_min_tracker.sv - per-frame minimum-SAD search with found/lost status
module sad_min_tracker #(
   parameter int               SAD_W      = 32,
   parameter int               COORD_W    = 10,
   parameter int               CNT_W      = 12,
   parameter logic [SAD_W-1:0] THRESH     = 32'd20000,
   parameter int               MISS_LIMIT = 4
) (
   input logic iCLK,
   input logic iRST_N,
   sad_min_tracker_if.slave bus
);
   localparam int                MISS_W   = $clog2(MISS_LIMIT + 1);
   localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);
   localparam logic [SAD_W-1:0]  SAD_ONES = {SAD_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT} state_t;

   state_t             r_state;
   logic [SAD_W-1:0]   r_run_min;
   logic [COORD_W-1:0] r_run_x;
   logic [COORD_W-1:0] r_run_y;
   logic [CNT_W-1:0]   r_cand_cnt;
   logic [MISS_W-1:0]  r_miss_cnt;
   logic [COORD_W-1:0] r_best_x;
   logic [COORD_W-1:0] r_best_y;
   logic [SAD_W-1:0]   r_best_sad;
   logic [CNT_W-1:0]   r_out_cnt;
   logic               r_found;
   logic               r_lost;
   logic               r_result_valid;
   logic               r_busy;

   logic              w_found;
   logic [MISS_W-1:0] w_miss_next;

   // An empty frame never counts as a match, whatever run_min holds.
   assign w_found     = (r_cand_cnt != '0) && (r_run_min <= THRESH);
   assign w_miss_next = w_found                  ? '0 :
                        (r_miss_cnt == MISS_MAX) ? MISS_MAX :
                                                   r_miss_cnt + MISS_W'(1);

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state        <= S_IDLE;
         r_run_min      <= SAD_ONES;
         r_run_x        <= '0;
         r_run_y        <= '0;
         r_cand_cnt     <= '0;
         r_miss_cnt     <= MISS_MAX;
         r_best_x       <= '0;
         r_best_y       <= '0;
         r_best_sad     <= SAD_ONES;
         r_out_cnt      <= '0;
         r_found        <= 1'b0;
         r_lost         <= 1'b1;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.iFRAME_START) begin
                  r_run_min  <= SAD_ONES;
                  r_cand_cnt <= '0;
                  r_state    <= S_SCAN;
                  r_busy     <= 1'b1;
               end
            end
            S_SCAN: begin
               if (bus.iFRAME_START) begin
                  r_run_min  <= SAD_ONES;
                  r_cand_cnt <= '0;
               end else begin
                  if (bus.iVALID) begin
                     if (r_cand_cnt != CNT_MAX)
                        r_cand_cnt <= r_cand_cnt + CNT_W'(1);
                     // Strict compare keeps the earliest of equal candidates.
                     if (bus.iSAD < r_run_min) begin
                        r_run_min <= bus.iSAD;
                        r_run_x   <= bus.iX;
                        r_run_y   <= bus.iY;
                     end
                  end
                  if (bus.iFRAME_END)
                     r_state <= S_REPORT;
               end
            end
            S_REPORT: begin
               r_best_sad     <= r_run_min;
               r_out_cnt      <= r_cand_cnt;
               r_found        <= w_found;
               r_miss_cnt     <= w_miss_next;
               r_lost         <= (w_miss_next == MISS_MAX);
               r_result_valid <= 1'b1;
               if (w_found) begin
                  r_best_x <= r_run_x;
                  r_best_y <= r_run_y;
               end
               if (bus.iFRAME_START) begin
                  r_run_min  <= SAD_ONES;
                  r_cand_cnt <= '0;
                  r_state    <= S_SCAN;
                  r_busy     <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.oBEST_X       = r_best_x;
   assign bus.oBEST_Y       = r_best_y;
   assign bus.oBEST_SAD     = r_best_sad;
   assign bus.oCAND_CNT     = r_out_cnt;
   assign bus.oFOUND        = r_found;
   assign bus.oLOST         = r_lost;
   assign bus.oRESULT_VALID = r_result_valid;
   assign bus.oBUSY         = r_busy;
endmodule

// File: tb/tb_sad_min_tracker.sv
// tb/tb_sad_min_tracker.sv - directed frame vectors for sad_min_tracker
module tb_sad_min_tracker;
   logic iCLK = 1'b0;
   logic iRST_N;

   sad_min_tracker_if #(.SAD_W(32), .COORD_W(10), .CNT_W(12)) bus ();

   sad_min_tracker dut (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .bus    (bus.slave)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      int              n;
      logic [2:0][31:0] sad;
      logic [2:0][9:0]  x;
      logic [2:0][9:0]  y;
      bit              end_last;
      logic [9:0]      ex;
      logic [9:0]      ey;
      logic [31:0]     esad;
      logic [11:0]     ecnt;
      logic            ef;
      logic            el;
   } vec_t;

   vec_t tv[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic add(input int n,
                      input logic [31:0] s0, input logic [9:0] x0, input logic [9:0] y0,
                      input logic [31:0] s1, input logic [9:0] x1, input logic [9:0] y1,
                      input logic [31:0] s2, input logic [9:0] x2, input logic [9:0] y2,
                      input bit el_end, input logic [9:0] ex, input logic [9:0] ey,
                      input logic [31:0] esad, input logic [11:0] ecnt,
                      input logic ef, input logic el);
      vec_t v;
      v.n = n;
      v.sad[0] = s0; v.x[0] = x0; v.y[0] = y0;
      v.sad[1] = s1; v.x[1] = x1; v.y[1] = y1;
      v.sad[2] = s2; v.x[2] = x2; v.y[2] = y2;
      v.end_last = el_end;
      v.ex = ex; v.ey = ey; v.esad = esad; v.ecnt = ecnt; v.ef = ef; v.el = el;
      tv.push_back(v);
   endtask

   task automatic drive_cand(input logic [31:0] s, input logic [9:0] x, input logic [9:0] y,
                             input logic with_end);
      bus.iVALID = 1'b1; bus.iSAD = s; bus.iX = x; bus.iY = y; bus.iFRAME_END = with_end;
      tick();
      bus.iVALID = 1'b0; bus.iFRAME_END = 1'b0;
   endtask

   task automatic pulse_start();
      bus.iFRAME_START = 1'b1;
      tick();
      bus.iFRAME_START = 1'b0;
   endtask

   task automatic pulse_end();
      bus.iFRAME_END = 1'b1;
      tick();
      bus.iFRAME_END = 1'b0;
   endtask

   task automatic chk_report(input string tag, input logic [9:0] ex, input logic [9:0] ey,
                             input logic [31:0] esad, input logic [11:0] ecnt,
                             input logic ef, input logic el);
      chk({tag, ".best_x"}, 64'(bus.oBEST_X), 64'(ex));
      chk({tag, ".best_y"}, 64'(bus.oBEST_Y), 64'(ey));
      chk({tag, ".best_sad"}, 64'(bus.oBEST_SAD), 64'(esad));
      chk({tag, ".cand_cnt"}, 64'(bus.oCAND_CNT), 64'(ecnt));
      chk({tag, ".found"}, 64'(bus.oFOUND), 64'(ef));
      chk({tag, ".lost"}, 64'(bus.oLOST), 64'(el));
   endtask

   initial begin
      iRST_N = 1'b0;
      bus.iFRAME_START = 1'b0; bus.iFRAME_END = 1'b0; bus.iVALID = 1'b0;
      bus.iSAD = '0; bus.iX = '0; bus.iY = '0;

      add(3, 500, 3, 4,  120, 7, 2,  300, 1, 1,  0, 7, 2, 120, 3, 1, 0);
      add(2, 90, 2, 2,   90, 5, 5,   0, 0, 0,    1, 2, 2, 90, 2, 1, 0);
      add(1, 120, 7, 2,  0, 0, 0,    0, 0, 0,    0, 7, 2, 120, 1, 1, 0);
      add(2, 50000, 4, 4, 60000, 1, 1, 0, 0, 0,  0, 7, 2, 50000, 2, 0, 0);
      add(1, 50000, 4, 4, 0, 0, 0,   0, 0, 0,    1, 7, 2, 50000, 1, 0, 0);
      add(1, 20001, 3, 3, 0, 0, 0,   0, 0, 0,    0, 7, 2, 20001, 1, 0, 0);
      add(1, 50000, 4, 4, 0, 0, 0,   0, 0, 0,    0, 7, 2, 50000, 1, 0, 1);
      add(0, 0, 0, 0,    0, 0, 0,    0, 0, 0,    0, 7, 2, 32'hFFFF_FFFF, 0, 0, 1);
      add(1, 10, 8, 8,   0, 0, 0,    0, 0, 0,    0, 8, 8, 10, 1, 1, 0);
      add(1, 20000, 6, 6, 0, 0, 0,   0, 0, 0,    0, 6, 6, 20000, 1, 1, 0);
      add(0, 0, 0, 0,    0, 0, 0,    0, 0, 0,    0, 6, 6, 32'hFFFF_FFFF, 0, 0, 0);
      add(3, 32'hFFFF_FFFE, 1, 3, 32'h8000_0000, 2, 3, 32'hFFFF_FFFF, 5, 5,
          0, 6, 6, 32'h8000_0000, 3, 0, 0);
      add(2, 5, 1023, 1023, 5, 0, 0, 0, 0, 0,   1, 1023, 1023, 5, 2, 1, 0);

      tick(); tick();
      chk_report("reset", 0, 0, 32'hFFFF_FFFF, 0, 0, 1);
      chk("reset.rv", 64'(bus.oRESULT_VALID), 64'd0);
      chk("reset.busy", 64'(bus.oBUSY), 64'd0);
      @(negedge iCLK);
      iRST_N = 1'b1;
      tick();

      for (int i = 0; i < tv.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         pulse_start();
         chk({tag, ".busy_scan"}, 64'(bus.oBUSY), 64'd1);
         for (int c = 0; c < tv[i].n; c++)
            drive_cand(tv[i].sad[c], tv[i].x[c], tv[i].y[c],
                       tv[i].end_last && (c == tv[i].n - 1));
         if (!tv[i].end_last || tv[i].n == 0)
            pulse_end();
         chk({tag, ".rv_early"}, 64'(bus.oRESULT_VALID), 64'd0);
         tick();
         chk({tag, ".rv"}, 64'(bus.oRESULT_VALID), 64'd1);
         chk_report(tag, tv[i].ex, tv[i].ey, tv[i].esad, tv[i].ecnt, tv[i].ef, tv[i].el);
         chk({tag, ".busy_idle"}, 64'(bus.oBUSY), 64'd0);
         tick();
         chk({tag, ".rv_drop"}, 64'(bus.oRESULT_VALID), 64'd0);
      end

      // Restart mid-frame: the 40@(9,9) candidate must be forgotten.
      pulse_start();
      drive_cand(40, 9, 9, 1'b0);
      pulse_start();
      chk("restart.no_rv", 64'(bus.oRESULT_VALID), 64'd0);
      drive_cand(200, 1, 2, 1'b0);
      pulse_end();
      chk("restart.no_rv2", 64'(bus.oRESULT_VALID), 64'd0);
      tick();
      chk("restart.rv", 64'(bus.oRESULT_VALID), 64'd1);
      chk_report("restart", 1, 2, 200, 1, 1, 0);
      tick();

      // Start during the REPORT cycle chains straight into the next scan.
      pulse_start();
      drive_cand(70, 3, 3, 1'b1);
      bus.iFRAME_START = 1'b1;
      tick();
      bus.iFRAME_START = 1'b0;
      chk("chain.rv", 64'(bus.oRESULT_VALID), 64'd1);
      chk_report("chain1", 3, 3, 70, 1, 1, 0);
      chk("chain.busy", 64'(bus.oBUSY), 64'd1);
      drive_cand(30, 4, 5, 1'b0);
      drive_cand(35, 6, 7, 1'b1);
      tick();
      chk("chain2.rv", 64'(bus.oRESULT_VALID), 64'd1);
      chk_report("chain2", 4, 5, 30, 2, 1, 0);
      tick();

      // Asynchronous reset partway through a scan.
      pulse_start();
      drive_cand(15, 2, 2, 1'b0);
      drive_cand(25, 3, 3, 1'b0);
      #2;
      iRST_N = 1'b0;
      #1;
      chk_report("arst", 0, 0, 32'hFFFF_FFFF, 0, 0, 1);
      chk("arst.rv", 64'(bus.oRESULT_VALID), 64'd0);
      chk("arst.busy", 64'(bus.oBUSY), 64'd0);
      @(negedge iCLK);
      iRST_N = 1'b1;
      bus.iVALID = 1'b1; bus.iSAD = 1; bus.iFRAME_END = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("arst.idle_rv%0d", k), 64'(bus.oRESULT_VALID), 64'd0);
         chk($sformatf("arst.idle_busy%0d", k), 64'(bus.oBUSY), 64'd0);
      end
      bus.iVALID = 1'b0; bus.iFRAME_END = 1'b0;
      chk_report("arst.after", 0, 0, 32'hFFFF_FFFF, 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sad_min_tracker.md
Name: sad_min_tracker

Overview:
Consumes the stream of per-candidate window SAD values produced by the pixel-difference summation stage (3 channels × 11×11 window, 32-bit sum). Over one search frame it tracks the candidate position with the smallest SAD and reports it once the frame closes. It also raises found/lost status for the sprite/object tracking logic downstream. All results are registered; the block is a single-clock sequential stage.

Parameters:
SAD_W, 32, width of incoming SAD value (matches summation output)
COORD_W, 10, width of candidate X and Y coordinates
CNT_W, 12, width of per-frame candidate counter
THRESH, 32'd20000, maximum SAD accepted as a valid match (inclusive)
MISS_LIMIT, 4, consecutive non-matching frames before oLOST asserts

Ports:
iCLK  in  1  system clock
iRST_N  in  1  reset, asynchronous, active-low
iFRAME_START  in  1  one-cycle pulse; opens a search frame
iFRAME_END  in  1  one-cycle pulse; closes the search frame
iVALID  in  1  iSAD/iX/iY valid this cycle
iSAD  in  SAD_W  window SAD for candidate (iX,iY)
iX  in  COORD_W  candidate column
iY  in  COORD_W  candidate row
oBEST_X  out  COORD_W  column of last accepted match
oBEST_Y  out  COORD_W  row of last accepted match
oBEST_SAD  out  SAD_W  minimum SAD of last reported frame
oCAND_CNT  out  CNT_W  candidates seen in last reported frame
oFOUND  out  1  last reported frame had min SAD <= THRESH
oLOST  out  1  miss counter at MISS_LIMIT
oRESULT_VALID  out  1  one-cycle pulse, outputs just updated
oBUSY  out  1  high in SCAN and REPORT

Behaviour:
- Reset (iRST_N low, asynchronous): state IDLE; oBEST_X=0, oBEST_Y=0, oBEST_SAD=all ones, oCAND_CNT=0, oFOUND=0, oLOST=1, oRESULT_VALID=0, oBUSY=0; internal run_min=all ones, miss_cnt=MISS_LIMIT, cand_cnt=0. Reset mid-frame discards the frame; no report.
- States: IDLE, SCAN, REPORT.
- IDLE: iVALID and iFRAME_END ignored. On iFRAME_START: run_min<=all ones, cand_cnt<=0, go SCAN.
- SCAN: on each iVALID, cand_cnt increments and saturates at 2^CNT_W-1. If iSAD < run_min (strict), then run_min<=iSAD and run_x/run_y<=iX/iY. Ties keep the earliest candidate.
- SCAN, iFRAME_END: go REPORT. An iVALID sample in the same cycle is included in the compare.
- SCAN, iFRAME_START (with or without iFRAME_END): restart. Partial frame discarded, run_min/cand_cnt cleared, stay SCAN, no report. Start wins over end.
- REPORT (exactly one cycle), registered at the edge leaving REPORT:
  - oBEST_SAD<=run_min, oCAND_CNT<=cand_cnt.
  - found = (cand_cnt!=0) && (run_min <= THRESH); oFOUND<=found.
  - If found: oBEST_X/Y<=run_x/run_y, miss_cnt<=0.
  - Else: oBEST_X/Y hold, miss_cnt increments and saturates at MISS_LIMIT.
  - oLOST follows the updated miss_cnt == MISS_LIMIT.
  - oRESULT_VALID=1 for the following cycle only.
- Leaving REPORT: next state is IDLE, or SCAN (counters cleared) if iFRAME_START is high during the REPORT cycle. iVALID in REPORT is ignored.
- Latency: iFRAME_END sampled at edge k → outputs updated and oRESULT_VALID high during the cycle after edge k+1.
- oBUSY = (state != IDLE), registered.
- Comparison is unsigned, full SAD_W width; no truncation.

Test Plan:
- Single frame: START; SADs 500@(3,4), 120@(7,2), 300@(1,1); END → oRESULT_VALID pulse 2 cycles after END, oBEST=(7,2), oBEST_SAD=120, oCAND_CNT=3, oFOUND=1, oLOST=0.
- Tie plus same-cycle end: 90@(2,2), then 90@(5,5) with iVALID in the END cycle → oBEST=(2,2), oCAND_CNT=2.
- Miss sequence: one found frame at (7,2), then 4 frames with all SAD=50000 → oBEST stays (7,2), oFOUND=0 each frame, oLOST=1 after the 4th report; a following frame with SAD 10 clears oLOST.
- Empty frame: START then END with no iVALID → oFOUND=0, oCAND_CNT=0, oBEST_SAD=all ones, miss_cnt increments.
- Restart: START, 40@(9,9), START, 200@(1,2), END → single report, oBEST=(1,2), oCAND_CNT=1. Separately, START in the REPORT cycle → next frame scans with no lost candidates.
- Async reset mid-SCAN after 2 candidates → all outputs at reset values immediately, no oRESULT_VALID; iVALID/iFRAME_END before the next START ignored.
